// File: rtl/my_nand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_nand_pkg
// Description : Shared defaults and helpers for the my_nand block.
//               DEFAULT_WIDTH  - default operand width
//               DEFAULT_CNT_W  - default statistics counter width
//               sat_max()      - all-ones value of a counter of given width
// Revision    : 1.0 - initial release
// ============================================================================
package my_nand_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // Returns 2^cnt_w - 1 in a 64-bit container; callers truncate to their
  // own width. A shift by 64 yields 0, so the subtraction still produces
  // all ones for the full-width case.
  function automatic logic [63:0] sat_max(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping.
//   clk   in   rising-edge clock
//   reset in   asynchronous active-high clear
//   inc   in   count this edge when high
//   count out  current count
//   sat   out  high while count is at its maximum
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import my_nand_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = (count_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/my_nand.sv
`default_nettype none
// ============================================================================
// Module      : my_nand
// Description : Bitwise NAND with a registered copy of the result and three
//               saturating statistics counters.
//   a, b        in   NAND operands (WIDTH)
//   w           out  combinational ~(a & b)
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   w_q         out  w registered on clk (all ones in reset)
//   eval_cnt    out  clock edges since reset
//   low_cnt     out  edges where some bit of w was 0
//   toggle_cnt  out  edges where w differed from w_q
//   sat         out  {toggle, low, eval} saturation flags
// Revision    : 1.0 - initial release
// ============================================================================
module my_nand
  import my_nand_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] w,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] w_q,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [2:0]       sat
);

  // Pure combinational path: independent of clk, reset and all state, so
  // the block works as a plain gate when clk/reset are left unconnected.
  assign w = ~(a & b);

  logic [WIDTH-1:0] w_q_d;
  logic             low_inc;
  logic             toggle_inc;

  always_comb begin
    w_q_d = w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= '1;
    end else begin
      w_q <= w_q_d;
    end
  end

  // Both conditions are evaluated against the values present at the edge,
  // i.e. the current w versus the previously captured w_q.
  assign low_inc    = ~(&w);
  assign toggle_inc = (w != w_q);

  sat_counter #(.CNT_W(CNT_W)) u_eval_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .count (eval_cnt),
    .sat   (sat[0])
  );

  sat_counter #(.CNT_W(CNT_W)) u_low_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (low_inc),
    .count (low_cnt),
    .sat   (sat[1])
  );

  sat_counter #(.CNT_W(CNT_W)) u_toggle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (toggle_inc),
    .count (toggle_cnt),
    .sat   (sat[2])
  );

endmodule
`default_nettype wire

// File: tb/tb_my_nand.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_nand
// Description : Self-checking bench for my_nand. Instance A is 4 bits wide
//               with 16-bit counters, instance B is 1 bit wide with 3-bit
//               counters (saturates quickly), instance P has clk/reset left
//               floating and is used as a plain gate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_nand;

  localparam int A_MAX = 65535;
  localparam int B_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic [3:0]  da, db, a_w, a_wq;
  logic [15:0] a_eval, a_low, a_tog;
  logic [2:0]  a_sat;
  // Instance B
  logic [0:0]  ea, eb, b_w, b_wq;
  logic [2:0]  b_eval, b_low, b_tog;
  logic [2:0]  b_sat;
  // Instance P (no clock, no reset activity)
  logic [0:0]  pa, pb, pw, p_wq;
  logic [15:0] p_eval, p_low, p_tog;
  logic [2:0]  p_sat;
  logic        pos_clk, pos_rst;

  my_nand #(.WIDTH(4), .CNT_W(16)) u_dut_a (
    .a(da), .b(db), .w(a_w), .clk(clk), .reset(rst), .w_q(a_wq),
    .eval_cnt(a_eval), .low_cnt(a_low), .toggle_cnt(a_tog), .sat(a_sat)
  );

  my_nand #(.WIDTH(1), .CNT_W(3)) u_dut_b (
    .a(ea), .b(eb), .w(b_w), .clk(clk), .reset(rst), .w_q(b_wq),
    .eval_cnt(b_eval), .low_cnt(b_low), .toggle_cnt(b_tog), .sat(b_sat)
  );

  my_nand #(.WIDTH(1), .CNT_W(16)) u_dut_p (
    .a(pa), .b(pb), .w(pw), .clk(pos_clk), .reset(pos_rst), .w_q(p_wq),
    .eval_cnt(p_eval), .low_cnt(p_low), .toggle_cnt(p_tog), .sat(p_sat)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] aw, awq;
    int         ae, al, at;
    logic [2:0] asat;
    logic       bw, bwq;
    int         be, bl, bt;
    logic [2:0] bsat;
  } exp_t;

  exp_t sb[$];

  logic [3:0] ma_wq;
  int         ma_eval, ma_low, ma_tog;
  logic       mb_wq;
  int         mb_eval, mb_low, mb_tog;

  function automatic int sinc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    ma_wq = 4'hF; ma_eval = 0; ma_low = 0; ma_tog = 0;
    mb_wq = 1'b1; mb_eval = 0; mb_low = 0; mb_tog = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state the
  // DUTs must show after the following rising edge.
  task automatic step(input logic [3:0] xa, input logic [3:0] xb,
                      input logic ya, input logic yb);
    logic [3:0] wa;
    logic       wb;
    exp_t       it;
    @(negedge clk);
    da = xa; db = xb; ea = ya; eb = yb;
    wa = ~(xa & xb);
    wb = ~(ya & yb);
    ma_eval = sinc(ma_eval, A_MAX);
    if (wa != 4'hF)  ma_low = sinc(ma_low, A_MAX);
    if (wa != ma_wq) ma_tog = sinc(ma_tog, A_MAX);
    ma_wq = wa;
    mb_eval = sinc(mb_eval, B_MAX);
    if (wb == 1'b0)  mb_low = sinc(mb_low, B_MAX);
    if (wb != mb_wq) mb_tog = sinc(mb_tog, B_MAX);
    mb_wq = wb;
    it.aw = wa; it.awq = ma_wq; it.ae = ma_eval; it.al = ma_low; it.at = ma_tog;
    it.asat = {ma_tog == A_MAX, ma_low == A_MAX, ma_eval == A_MAX};
    it.bw = wb; it.bwq = mb_wq; it.be = mb_eval; it.bl = mb_low; it.bt = mb_tog;
    it.bsat = {mb_tog == B_MAX, mb_low == B_MAX, mb_eval == B_MAX};
    sb.push_back(it);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_wq"},   {28'd0, a_wq},   32'hF);
    check({tag, "_a_eval"}, {16'd0, a_eval}, 32'd0);
    check({tag, "_a_low"},  {16'd0, a_low},  32'd0);
    check({tag, "_a_tog"},  {16'd0, a_tog},  32'd0);
    check({tag, "_a_sat"},  {29'd0, a_sat},  32'd0);
    check({tag, "_b_wq"},   {31'd0, b_wq},   32'd1);
    check({tag, "_b_eval"}, {29'd0, b_eval}, 32'd0);
    check({tag, "_b_low"},  {29'd0, b_low},  32'd0);
    check({tag, "_b_tog"},  {29'd0, b_tog},  32'd0);
    check({tag, "_b_sat"},  {29'd0, b_sat},  32'd0);
  endtask

  // Reset raised between edges; state must clear before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_reset_state(tag);
  endtask

  // Release just after a rising edge so the next falling edge drives the
  // first modelled cycle with no unmodelled edge in between.
  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("mon_a_w",    {28'd0, a_w},    {28'd0, mon_e.aw});
      check("mon_a_wq",   {28'd0, a_wq},   {28'd0, mon_e.awq});
      check("mon_a_eval", {16'd0, a_eval}, mon_e.ae);
      check("mon_a_low",  {16'd0, a_low},  mon_e.al);
      check("mon_a_tog",  {16'd0, a_tog},  mon_e.at);
      check("mon_a_sat",  {29'd0, a_sat},  {29'd0, mon_e.asat});
      check("mon_b_w",    {31'd0, b_w},    {31'd0, mon_e.bw});
      check("mon_b_wq",   {31'd0, b_wq},   {31'd0, mon_e.bwq});
      check("mon_b_eval", {29'd0, b_eval}, mon_e.be);
      check("mon_b_low",  {29'd0, b_low},  mon_e.bl);
      check("mon_b_tog",  {29'd0, b_tog},  mon_e.bt);
      check("mon_b_sat",  {29'd0, b_sat},  {29'd0, mon_e.bsat});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ra, rb;
    logic       sa, sb_bit;
    logic [0:0] exp_p [4];
    pos_clk = 1'bz; pos_rst = 1'bz;
    pa = 1'b0; pb = 1'b0;
    da = 4'b1100; db = 4'b1010; ea = 1'b0; eb = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    check_reset_state("rst_init");
    check("rst_w_indep", {28'd0, a_w}, 32'h7);

    // Truth table on the clockless instance.
    exp_p[0] = 1'b1; exp_p[1] = 1'b1; exp_p[2] = 1'b1; exp_p[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pa = i[1]; pb = i[0];
      #1;
      check($sformatf("tt_ab%0d", i), {31'd0, pw}, {31'd0, exp_p[i]});
    end

    // Four cycles of ab=11 from reset.
    release_reset();
    for (int i = 0; i < 4; i++) step(4'hF, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #2;
    check("hold11_eval", {16'd0, a_eval}, 32'd4);
    check("hold11_low",  {16'd0, a_low},  32'd4);
    check("hold11_tog",  {16'd0, a_tog},  32'd1);
    check("hold11_wq",   {28'd0, a_wq},   32'd0);

    // Alternate 11 / 00 for six cycles.
    async_reset("rst_alt");
    release_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(4'hF, 4'hF, 1'b1, 1'b1);
      else            step(4'h0, 4'h0, 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    check("alt_tog", {16'd0, a_tog}, 32'd6);
    check("alt_low", {16'd0, a_low}, 32'd3);
    check("alt_b_tog", {29'd0, b_tog}, 32'd6);

    // Multi-bit operands: immediate w, registered after one edge.
    step(4'b1100, 4'b1010, 1'b1, 1'b0);
    #1 check("w4_comb", {28'd0, a_w}, 32'h7);
    @(posedge clk); #2;
    check("w4_reg", {28'd0, a_wq}, 32'h7);

    // Ten cycles on 3-bit counters: eval sticks at 7.
    async_reset("rst_sat");
    release_reset();
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      step(ra, rb, ra[0], rb[0]);
    end
    @(posedge clk); #2;
    check("sat_b_eval", {29'd0, b_eval}, 32'd7);
    check("sat_b_flag0", {31'd0, b_sat[0]}, 32'd1);

    // Reset mid-operation after five cycles.
    async_reset("rst_pre5");
    release_reset();
    for (int i = 0; i < 5; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      step(ra, rb, ra[1], rb[1]);
    end
    async_reset("rst_mid");
    release_reset();

    // Random traffic with occasional forced all-ones and resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        ra = 4'hF; rb = 4'hF; sa = 1'b1; sb_bit = 1'b1;
      end else begin
        ra = 4'($urandom); rb = 4'($urandom);
        sa = 1'($urandom); sb_bit = 1'($urandom);
      end
      step(ra, rb, sa, sb_bit);
      if (i % 97 == 96) begin
        async_reset($sformatf("rst_rand%0d", i));
        release_reset();
      end
    end

    @(posedge clk); #2;
    check("sb_drain", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/my_nand.md
MY_NAND -- requirements
Module: my_nand

Interface
REQ-001 Parameter WIDTH, default 1: bit width of a, b, w and w_q.
REQ-002 Parameter CNT_W, default 16: width of every statistics counter.
REQ-003 clk  input  1: single clock; all registers update on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 a  input  WIDTH: first NAND operand.
REQ-006 b  input  WIDTH: second NAND operand.
REQ-007 w  output  WIDTH: combinational NAND result.
REQ-008 w_q  output  WIDTH: w registered on clk.
REQ-009 eval_cnt  output  CNT_W: count of clock cycles since reset.
REQ-010 low_cnt  output  CNT_W: count of cycles where any bit of w was 0.
REQ-011 toggle_cnt  output  CNT_W: count of cycles where w differed from w_q.
REQ-012 sat  output  3: saturation flags {toggle_cnt, low_cnt, eval_cnt}.
REQ-013 Port declaration order SHALL be a, b, w, clk, reset, w_q, eval_cnt, low_cnt, toggle_cnt, sat, so that positional instantiation (a, b, w) works without connecting clk or reset.

Function
REQ-014 w SHALL equal ~(a & b) bitwise, purely combinational, zero cycles of latency.
REQ-015 w SHALL NOT depend on clk, reset or any register; it SHALL be valid even when clk and reset are unconnected.
REQ-016 For WIDTH=1 the truth table SHALL be 00->1, 01->1, 10->1, 11->0.
REQ-017 w_q SHALL capture w on every rising clk edge while reset is low.
REQ-018 eval_cnt SHALL increment by 1 on every rising clk edge while reset is low.
REQ-019 low_cnt SHALL increment on a rising edge when (&w)==0 at that edge.
REQ-020 toggle_cnt SHALL increment on a rising edge when w != w_q at that edge; the first edge after reset compares against the w_q reset value.
REQ-021 Every counter SHALL saturate at 2^CNT_W-1 and never wrap around.
REQ-022 Each sat bit SHALL be 1 exactly when its counter equals 2^CNT_W-1.
REQ-023 Counters SHALL update independently; several counters may increment on the same edge.
REQ-024 X or Z on a or b SHALL propagate to w per standard NAND semantics; no masking.

Reset
REQ-025 While reset is high: w_q = all ones, eval_cnt = low_cnt = toggle_cnt = 0, sat = 0, applied immediately without waiting for a clock edge.
REQ-026 Reset asserted mid-operation SHALL clear all registers at once; counting SHALL resume from 0 on the first rising edge after reset deasserts.
REQ-027 Reset SHALL NOT affect w.

Structure
REQ-028 Package my_nand_pkg SHALL hold the default constants for WIDTH and CNT_W and the saturation-max helper function.
REQ-029 A sub-module sat_counter (parameter CNT_W; ports clk, reset, inc, count, sat) SHALL be instantiated three times, once per counter.
REQ-030 The NAND datapath and the w_q register SHALL live in my_nand; there SHALL be no other sub-modules.

Verification
REQ-031 With clk and reset unconnected, apply ab=00,01,10,11, 1 ns apart -> w = 1,1,1,0 with no X.
REQ-032 Hold reset high, then release it and run 4 cycles with ab=11 -> eval_cnt=4, low_cnt=4, toggle_cnt=1, w_q=0.
REQ-033 After reset, alternate ab between 11 and 00 every cycle for 6 cycles -> toggle_cnt=6, low_cnt=3.
REQ-034 With CNT_W=3, run 10 cycles -> eval_cnt=7, sat[0]=1, with no wrap to 0.
REQ-035 Assert reset asynchronously between clock edges after 5 cycles -> all counters read 0 and w_q is all ones before the next edge.
REQ-036 With WIDTH=4, a=4'b1100 and b=4'b1010 -> w=4'b0111 at once, and w_q=4'b0111 after the next edge.
